// File: rtl/winner_pkg.sv
// Shared definitions for the winner_tally block: round-result codes,
// match state encoding and the channel-count width helper.
package winner_pkg;

    typedef logic [1:0] wr_t;

    localparam wr_t WR_NONE = 2'b00;
    localparam wr_t WR_P1   = 2'b01;
    localparam wr_t WR_P2   = 2'b10;
    localparam wr_t WR_TIE  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Width needed to hold a count from 0 to n_ch inclusive.
    function automatic int cnt_width(input int n_ch);
        return $clog2(n_ch + 1);
    endfunction

endpackage

// File: rtl/winner_tally_if.sv
// Handshake and result bus between the comparator array, winner_tally
// and the display/score controller. The master side drives the vector
// stream and clear; the slave side (winner_tally) returns results.
interface winner_tally_if #(
    parameter int N_CH    = 5,
    parameter int SCORE_W = 4
);
    logic                 clear;
    logic                 in_valid;
    logic                 in_ready;
    logic [2*N_CH-1:0]    cmp_vec;
    logic                 out_valid;
    logic [1:0]           out_wr;
    logic [SCORE_W-1:0]   score1;
    logic [SCORE_W-1:0]   score2;
    logic                 match_done;
    logic [1:0]           match_winner;

    modport master (
        output clear,
        output in_valid,
        output cmp_vec,
        input  in_ready,
        input  out_valid,
        input  out_wr,
        input  score1,
        input  score2,
        input  match_done,
        input  match_winner
    );

    modport slave (
        input  clear,
        input  in_valid,
        input  cmp_vec,
        output in_ready,
        output out_valid,
        output out_wr,
        output score1,
        output score2,
        output match_done,
        output match_winner
    );
endinterface

// File: rtl/winner_popcount.sv
// Combinational per-player channel counter: c1 counts channels whose
// bit0 is set (P1 hit), c2 counts channels whose bit1 is set (P2 hit).
module winner_popcount #(
    parameter int N_CH = 5,
    parameter int CW   = 3
) (
    input  logic [2*N_CH-1:0] vec,
    output logic [CW-1:0]     c1,
    output logic [CW-1:0]     c2
);

    // Sum the two bits of every channel into separate counters.
    always_comb begin
        c1 = '0;
        c2 = '0;
        for (int i = 0; i < N_CH; i++) begin
            c1 = c1 + CW'(vec[2*i]);
            c2 = c2 + CW'(vec[2*i+1]);
        end
    end

endmodule

// File: rtl/winner_tally.sv
// winner_tally: two-stage round-winner pipeline with per-player match
// scoring. Stage 1 registers the channel counts, stage 2 registers the
// round result and updates the scores on the same edge.
// Optional build macro: WINNER_LAST_TIEBREAK_EN -- when defined, a tie
// round resolves to the most recent decisive round winner since the
// last clear/reset.
module winner_tally
    import winner_pkg::*;
#(
    parameter int N_CH    = 5,
    parameter int SCORE_W = 4,
    parameter int TARGET  = 3
) (
    input  logic          newClk,
    input  logic          rst,
    winner_tally_if.slave bus
);

    localparam int                 CW        = cnt_width(N_CH);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] TARGET_V  = SCORE_W'(TARGET);

    logic               accept;
    logic [CW-1:0]      pc_c1;
    logic [CW-1:0]      pc_c2;

    logic               s1_valid;
    logic [CW-1:0]      s1_c1;
    logic [CW-1:0]      s1_c2;

    wr_t                raw_wr;
    wr_t                res_wr;

    state_t             state_q;
    state_t             state_d;

    logic [SCORE_W-1:0] score1_q;
    logic [SCORE_W-1:0] score2_q;
    logic [SCORE_W-1:0] score1_nx;
    logic [SCORE_W-1:0] score2_nx;
    logic               score_upd;
    logic               hit1;
    logic               hit2;

    logic               out_valid_q;
    wr_t                out_wr_q;
    wr_t                winner_q;

`ifdef WINNER_LAST_TIEBREAK_EN
    wr_t                last_q;
`endif

    assign accept = bus.in_valid && bus.in_ready && !bus.clear;

    winner_popcount #(
        .N_CH (N_CH),
        .CW   (CW)
    ) u_popcount (
        .vec (bus.cmp_vec),
        .c1  (pc_c1),
        .c2  (pc_c2)
    );

    // Stage 1: capture the channel counts of each accepted vector.
    always_ff @(posedge newClk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_c1    <= '0;
            s1_c2    <= '0;
        end else if (bus.clear) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_c1 <= pc_c1;
                s1_c2 <= pc_c2;
            end
        end
    end

    // Round decision from the stage-1 counts, with optional tie-break.
    always_comb begin
        raw_wr = WR_NONE;
        if (s1_c1 > s1_c2) begin
            raw_wr = WR_P1;
        end else if (s1_c1 < s1_c2) begin
            raw_wr = WR_P2;
        end else if (s1_c1 != '0) begin
            raw_wr = WR_TIE;
        end
`ifdef WINNER_LAST_TIEBREAK_EN
        res_wr = ((raw_wr == WR_TIE) && (last_q != WR_NONE)) ? last_q : raw_wr;
`else
        res_wr = raw_wr;
`endif
    end

    // Saturating next-score values and target detection. Scores only move
    // while the match is still open; in DONE they are frozen.
    always_comb begin
        score_upd = s1_valid && (state_q != DONE);
        score1_nx = score1_q;
        score2_nx = score2_q;
        if ((res_wr == WR_P1) && (score1_q != SCORE_MAX)) begin
            score1_nx = score1_q + SCORE_W'(1);
        end
        if ((res_wr == WR_P2) && (score2_q != SCORE_MAX)) begin
            score2_nx = score2_q + SCORE_W'(1);
        end
        hit1 = score_upd && (res_wr == WR_P1) && (score1_nx == TARGET_V)
               && (score1_q != TARGET_V);
        hit2 = score_upd && (res_wr == WR_P2) && (score2_nx == TARGET_V)
               && (score2_q != TARGET_V);
    end

`ifdef WINNER_LAST_TIEBREAK_EN
    // Remember the latest decisive round outcome for tie resolution.
    always_ff @(posedge newClk or posedge rst) begin
        if (rst) begin
            last_q <= WR_NONE;
        end else if (bus.clear) begin
            last_q <= WR_NONE;
        end else if (s1_valid && ((raw_wr == WR_P1) || (raw_wr == WR_P2))) begin
            last_q <= raw_wr;
        end
    end
`endif

    // Stage 2: publish the round result as a one-cycle pulse; out_wr holds.
    always_ff @(posedge newClk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_wr_q    <= WR_NONE;
        end else if (bus.clear) begin
            out_valid_q <= 1'b0;
            out_wr_q    <= WR_NONE;
        end else begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                out_wr_q <= res_wr;
            end
        end
    end

    // Score counters, updated on the same edge that raises out_valid.
    always_ff @(posedge newClk or posedge rst) begin
        if (rst) begin
            score1_q <= '0;
            score2_q <= '0;
        end else if (bus.clear) begin
            score1_q <= '0;
            score2_q <= '0;
        end else if (score_upd) begin
            score1_q <= score1_nx;
            score2_q <= score2_nx;
        end
    end

    // Latch the match winner on the edge that enters DONE.
    always_ff @(posedge newClk or posedge rst) begin
        if (rst) begin
            winner_q <= WR_NONE;
        end else if (bus.clear) begin
            winner_q <= WR_NONE;
        end else if (state_q == RUN) begin
            if (hit1) begin
                winner_q <= WR_P1;
            end else if (hit2) begin
                winner_q <= WR_P2;
            end
        end
    end

    // Match state register.
    always_ff @(posedge newClk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Match state transitions; clear overrides every state.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = RUN;
                RUN:     if (hit1 || hit2) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.in_ready     = (state_q != DONE) && !rst;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_wr       = out_wr_q;
    assign bus.score1       = score1_q;
    assign bus.score2       = score2_q;
    assign bus.match_done   = (state_q == DONE);
    assign bus.match_winner = winner_q;

endmodule
